// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_sched slice.
//   DW        : datapath width (4 bits)
//   OP_*      : ALU opcode constants
//   state_t   : scheduler FSM states; MUL exists only when ALU_SCHED_MUL_EN
//               is defined (optional shift-add multiplier).
package alu_pkg;

    localparam int DW = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
`ifdef ALU_SCHED_MUL_EN
        MUL,
`endif
        RESP
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational 4-bit ALU.
// Ports:
//   a, b      : operands
//   op        : opcode (see alu_pkg OP_*)
//   c         : result
//   zero      : c==0, add/sub only (0 for every other opcode)
//   overflow  : signed two's-complement overflow, add/sub only
//   carry     : bit 4 of the 5-bit add result / borrow of sub
module alu_core
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] c,
    output logic          zero,
    output logic          overflow,
    output logic          carry
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        c        = '0;
        zero     = 1'b0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (op)
            OP_ADD: begin
                c        = sum[DW-1:0];
                carry    = sum[DW];
                zero     = (sum[DW-1:0] == '0);
                // Same-sign operands producing a result of the other sign.
                overflow = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                c        = diff[DW-1:0];
                carry    = diff[DW];
                zero     = (diff[DW-1:0] == '0);
                overflow = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            OP_NOT: c = ~a;
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_SLT: c = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  c = {{(DW-1){1'b0}}, (a == b)};
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched -- two-port request scheduler in front of a single ALU.
// Optional feature macro: ALU_SCHED_MUL_EN (4-cycle shift-add multiplier).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid[1:0]           : per-port request valid
//   req_ready[1:0]           : per-port accept strobe (valid & ready)
//   req_op0/1, req_mul0/1    : opcode / multiply select per port
//   req_a0/b0, req_a1/b1     : operands per port
//   rsp_valid, rsp_ready     : response handshake (held until taken)
//   rsp_id, rsp_c            : source port, result
//   rsp_zero/overflow/carry  : result flags
//   rsp_err                  : unsupported request (mul with no multiplier)
// Parameter RR_EN: 1 = round-robin between ports, 0 = port 0 always wins.
module alu_sched
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [2:0]    req_op0,
    input  logic [2:0]    req_op1,
    input  logic          req_mul0,
    input  logic          req_mul1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_c,
    output logic          rsp_zero,
    output logic          rsp_overflow,
    output logic          rsp_carry,
    output logic          rsp_err
);

    state_t        state_reg, state_next;
    logic [2:0]    op_reg;
    logic          mul_reg;
    logic [DW-1:0] a_reg, b_reg;
    logic          id_reg;
    logic          rr_last_reg;     // port granted most recently

    logic          rsp_id_reg, rsp_zero_reg, rsp_overflow_reg, rsp_carry_reg, rsp_err_reg;
    logic [DW-1:0] rsp_c_reg;

    logic          grant;
    logic          accept;
    logic [2:0]    sel_op;
    logic          sel_mul;
    logic [DW-1:0] sel_a, sel_b;

    logic [DW-1:0] alu_a, alu_b, alu_c;
    logic [2:0]    alu_op;
    logic          alu_zero, alu_overflow, alu_carry;

`ifdef ALU_SCHED_MUL_EN
    // Product register {hi_reg, lo_reg}; lo_reg starts as the multiplier and
    // is shifted out LSB first while product bits shift in from the top.
    logic [DW-1:0] hi_reg, lo_reg;
    logic [1:0]    cnt_reg;
    logic [DW-1:0] hi_step, lo_step;
`endif

    // Arbitration: a lone valid port wins; a tie goes to the port not
    // granted last (round-robin) or to port 0 (fixed priority).
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = (RR_EN != 0) ? ~rr_last_reg : 1'b0;
        end else begin
            grant = ~req_valid[0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && !rst && req_valid[gi]
                                   && (grant == 1'(gi));
        end
    endgenerate

    assign accept  = |req_ready;
    assign sel_op  = grant ? req_op1  : req_op0;
    assign sel_mul = grant ? req_mul1 : req_mul0;
    assign sel_a   = grant ? req_a1   : req_a0;
    assign sel_b   = grant ? req_b1   : req_b0;

    // ALU operand mux: latched request normally; during MUL the add path
    // accumulates the multiplicand into the high half of the product.
    always_comb begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = op_reg;
`ifdef ALU_SCHED_MUL_EN
        if (state_reg == MUL) begin
            alu_a  = hi_reg;
            alu_b  = lo_reg[0] ? a_reg : '0;
            alu_op = OP_ADD;
        end
`endif
    end

    alu_core u_alu_core (
        .a        (alu_a),
        .b        (alu_b),
        .op       (alu_op),
        .c        (alu_c),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .carry    (alu_carry)
    );

`ifdef ALU_SCHED_MUL_EN
    assign hi_step = {alu_carry, alu_c[DW-1:1]};
    assign lo_step = {alu_c[0], lo_reg[DW-1:1]};
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SCHED_MUL_EN
                    state_next = sel_mul ? MUL : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: state_next = RESP;
`ifdef ALU_SCHED_MUL_EN
            MUL:  if (cnt_reg == 2'd3) state_next = RESP;
`endif
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            op_reg           <= '0;
            mul_reg          <= 1'b0;
            a_reg            <= '0;
            b_reg            <= '0;
            id_reg           <= 1'b0;
            rr_last_reg      <= 1'b1;   // next tie goes to port 0
            rsp_id_reg       <= 1'b0;
            rsp_c_reg        <= '0;
            rsp_zero_reg     <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_carry_reg    <= 1'b0;
            rsp_err_reg      <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
            hi_reg           <= '0;
            lo_reg           <= '0;
            cnt_reg          <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= sel_op;
                mul_reg     <= sel_mul;
                a_reg       <= sel_a;
                b_reg       <= sel_b;
                id_reg      <= grant;
                rr_last_reg <= grant;
`ifdef ALU_SCHED_MUL_EN
                hi_reg      <= '0;
                lo_reg      <= sel_b;
                cnt_reg     <= '0;
`endif
            end
            if (state_reg == EXEC) begin
                rsp_id_reg <= id_reg;
                if (mul_reg) begin
                    // Only reachable without the multiplier: flag as unsupported.
                    rsp_c_reg        <= '0;
                    rsp_zero_reg     <= 1'b0;
                    rsp_overflow_reg <= 1'b0;
                    rsp_carry_reg    <= 1'b0;
                    rsp_err_reg      <= 1'b1;
                end else begin
                    rsp_c_reg        <= alu_c;
                    rsp_zero_reg     <= alu_zero;
                    rsp_overflow_reg <= alu_overflow;
                    rsp_carry_reg    <= alu_carry;
                    rsp_err_reg      <= 1'b0;
                end
            end
`ifdef ALU_SCHED_MUL_EN
            if (state_reg == MUL) begin
                hi_reg  <= hi_step;
                lo_reg  <= lo_step;
                cnt_reg <= cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    rsp_id_reg       <= id_reg;
                    rsp_c_reg        <= lo_step;
                    rsp_zero_reg     <= (lo_step == '0);
                    rsp_overflow_reg <= (hi_step != '0);
                    rsp_carry_reg    <= 1'b0;
                    rsp_err_reg      <= 1'b0;
                end
            end
`endif
        end
    end

    assign rsp_valid    = (state_reg == RESP);
    assign rsp_id       = rsp_id_reg;
    assign rsp_c        = rsp_c_reg;
    assign rsp_zero     = rsp_zero_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign rsp_carry    = rsp_carry_reg;
    assign rsp_err      = rsp_err_reg;

endmodule
